// File: rtl/sprite_pkg.sv
// sprite_pkg: shared palette, colour-select and animation-state types plus ctrl field offsets
package sprite_pkg;
    typedef enum logic [1:0] {PLT_KEY, PLT_WHITE, PLT_BODY, PLT_SHADE} plt_code_t;
    typedef enum logic [1:0] {COL_RED, COL_GREEN, COL_BLUE, COL_CYAN} col_sel_t;
    typedef enum logic {ANI_MANUAL, ANI_AUTO} ani_state_t;
    function automatic int ctrl_auto(input int fw);
        return fw;
    endfunction
    function automatic int ctrl_col(input int fw);
        return fw + 1;
    endfunction
    function automatic int ctrl_mirror(input int fw);
        return fw + 3;
    endfunction
endpackage

// File: rtl/sprite_bitmap_ram.sv
// sprite_bitmap_ram: simple dual-port RAM, synchronous read, read-first on address collision
module sprite_bitmap_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_w,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr_r,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr_w] <= din;
        dout <= mem[addr_r];
    end
endmodule

// File: rtl/anim_sprite_src.sv
// anim_sprite_src: animated sprite pixel source, 2-cycle latency RGB with chroma key.
// Define ANIM_SPRITE_MIRROR_EN to enable horizontal mirroring via ctrl[FW+3].
module anim_sprite_src
    import sprite_pkg::*;
#(
    parameter int          CD        = 12,
    parameter int          H_SIZE    = 16,
    parameter int          V_SIZE    = 16,
    parameter int          NFRAME    = 4,
    parameter int          ANI_DIV   = 8,
    parameter logic [CD-1:0] KEY_COLOR = '0,
    localparam int         FW        = $clog2(NFRAME),
    localparam int         HW        = $clog2(H_SIZE),
    localparam int         VW        = $clog2(V_SIZE),
    localparam int         ADDR      = FW + VW + HW,
    localparam int         CTRL_W    = FW + 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       x,
    input  logic [10:0]       y,
    input  logic [10:0]       x0,
    input  logic [10:0]       y0,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              we,
    input  logic [ADDR-1:0]   addr_w,
    input  logic [1:0]        pixel_in,
    output logic [CD-1:0]     sprite_rgb,
    output logic              hit
);
    localparam int CW = CD / 3;
    localparam int DW = (ANI_DIV > 1) ? $clog2(ANI_DIV) : 1;

    logic [11:0]   xr, yr;
    logic          in_region, is_zero, prev_zero, tick, region_d1;
    logic [FW-1:0] manual_id, ani_reg, sid;
    logic [DW-1:0] div_cnt;
    logic          div_last;
    ani_state_t    state;
    logic [HW-1:0] xc;
    logic [ADDR-1:0] addr_r;
    logic [1:0]    code_raw;
    plt_code_t     code;
    col_sel_t      col;
    logic [CW-1:0] lv;
    logic [CD-1:0] body, rgb;

    // Zero-extended subtraction: bit 11 set means the scan is left/above the origin
    assign xr        = {1'b0, x} - {1'b0, x0};
    assign yr        = {1'b0, y} - {1'b0, y0};
    assign in_region = ~|xr[11:HW] && ~|yr[11:VW];
    assign is_zero   = (x == '0) && (y == '0);
    assign tick      = is_zero && !prev_zero;
    assign manual_id = ctrl[FW-1:0];
    assign div_last  = div_cnt == DW'(ANI_DIV - 1);
    assign sid       = (state == ANI_MANUAL) ? manual_id : ani_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ANI_MANUAL;
            ani_reg   <= '0;
            div_cnt   <= '0;
            prev_zero <= 1'b0;
        end else begin
            prev_zero <= is_zero;
            state     <= ctrl[ctrl_auto(FW)] ? ANI_AUTO : ANI_MANUAL;
            if (state == ANI_MANUAL) begin
                ani_reg <= manual_id;
                div_cnt <= '0;
            end else if (tick) begin
                div_cnt <= div_last ? '0 : div_cnt + 1'b1;
                if (div_last) ani_reg <= ani_reg + 1'b1;
            end
        end
    end

`ifdef ANIM_SPRITE_MIRROR_EN
    assign xc = ctrl[ctrl_mirror(FW)] ? ~xr[HW-1:0] : xr[HW-1:0];
`else
    logic unused_mirror;
    assign unused_mirror = ctrl[ctrl_mirror(FW)];
    assign xc = xr[HW-1:0];
`endif

    assign addr_r = {sid, yr[VW-1:0], xc};

    sprite_bitmap_ram #(.ADDR_WIDTH(ADDR), .DATA_WIDTH(2)) u_ram (
        .clk    (clk),
        .we     (we),
        .addr_w (addr_w),
        .din    (pixel_in),
        .addr_r (addr_r),
        .dout   (code_raw)
    );

    assign code = plt_code_t'(code_raw);
    assign col  = col_sel_t'(ctrl[ctrl_col(FW) +: 2]);
    assign lv   = (code == PLT_SHADE) ? {1'b0, {(CW-1){1'b1}}} : {CW{1'b1}};
    assign body = (col == COL_RED)   ? {lv, {CW{1'b0}}, {CW{1'b0}}} :
                  (col == COL_GREEN) ? {{CW{1'b0}}, lv, {CW{1'b0}}} :
                  (col == COL_BLUE)  ? {{CW{1'b0}}, {CW{1'b0}}, lv} :
                                       {{CW{1'b0}}, lv, lv};
    assign rgb  = (code == PLT_KEY)   ? KEY_COLOR :
                  (code == PLT_WHITE) ? {CD{1'b1}} : body;

    always_ff @(posedge clk) begin
        if (reset) begin
            region_d1  <= 1'b0;
            sprite_rgb <= KEY_COLOR;
            hit        <= 1'b0;
        end else begin
            region_d1  <= in_region;
            sprite_rgb <= region_d1 ? rgb : KEY_COLOR;
            hit        <= region_d1 && (code != PLT_KEY);
        end
    end
endmodule

// File: tb/tb_anim_sprite_src.sv
// tb_anim_sprite_src: directed checks of anim_sprite_src in the default (no mirror) build
module tb_anim_sprite_src;
    logic        clk, reset, we, hit;
    logic [10:0] x, y, x0, y0;
    logic [5:0]  ctrl;
    logic [9:0]  addr_w;
    logic [1:0]  pixel_in;
    logic [11:0] sprite_rgb;
    int total = 0;
    int bad = 0;
    logic [11:0] fr_rgb [4];

    anim_sprite_src dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .x0(x0), .y0(y0), .ctrl(ctrl),
        .we(we), .addr_w(addr_w), .pixel_in(pixel_in), .sprite_rgb(sprite_rgb), .hit(hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] er, input logic eh);
        total++;
        assert (sprite_rgb === er && hit === eh) else begin
            bad++;
            $error("FAIL %s: got rgb=%h hit=%b, want rgb=%h hit=%b", tag, sprite_rgb, hit, er, eh);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [1:0] c);
        we = 1'b1; addr_w = a; pixel_in = c;
        cyc(1);
        we = 1'b0;
    endtask

    task automatic probe(input logic [10:0] px, input logic [10:0] py, input string tag,
                         input logic [11:0] er, input logic eh);
        x = px; y = py;
        cyc(2);
        chk(tag, er, eh);
    endtask

    task automatic frame_tick();
        x = 0; y = 0;
        cyc(1);
        x = 100; y = 100;
        cyc(1);
    endtask

    initial begin
        fr_rgb = '{12'hFFF, 12'hF00, 12'h700, 12'h000};
        reset = 1'b1; we = 1'b0; addr_w = '0; pixel_in = '0;
        x = 100; y = 100; x0 = 100; y0 = 100; ctrl = 6'b000000;
        cyc(3);
        chk("reset", 12'h000, 1'b0);
        reset = 1'b0;

        wr({2'd0, 4'd0, 4'd0}, 2'b10);
        probe(100, 100, "body_red", 12'hF00, 1'b1);
        probe(99, 100, "left_edge", 12'h000, 1'b0);
        probe(100, 99, "top_edge", 12'h000, 1'b0);
        probe(116, 100, "right_edge", 12'h000, 1'b0);

        wr({2'd0, 4'd0, 4'd1}, 2'b11);
        wr({2'd0, 4'd0, 4'd2}, 2'b01);
        wr({2'd0, 4'd0, 4'd3}, 2'b00);
        ctrl = 6'b010000;
        probe(101, 100, "shade_blue", 12'h007, 1'b1);
        probe(102, 100, "white", 12'hFFF, 1'b1);
        probe(103, 100, "transparent", 12'h000, 1'b0);
        ctrl = 6'b011000;
        probe(100, 100, "body_cyan", 12'h0FF, 1'b1);
        ctrl = 6'b001000;
        probe(100, 100, "body_green", 12'h0F0, 1'b1);

        wr({2'd0, 4'd0, 4'd15}, 2'b00);
        ctrl = 6'b100000;
        probe(100, 100, "mirror_ignored_c0", 12'hF00, 1'b1);
        probe(115, 100, "mirror_ignored_c15", 12'h000, 1'b0);
        ctrl = 6'b000000;

        // Read and overwrite the same address in one cycle: old code must come out
        x = 100; y = 100; we = 1'b1; addr_w = '0; pixel_in = 2'b01;
        cyc(1);
        we = 1'b0;
        cyc(1);
        chk("read_first_old", 12'hF00, 1'b1);
        probe(100, 100, "read_first_new", 12'hFFF, 1'b1);

        wr({2'd1, 4'd0, 4'd0}, 2'b10);
        wr({2'd2, 4'd0, 4'd0}, 2'b11);
        wr({2'd3, 4'd0, 4'd0}, 2'b00);
        ctrl = 6'b000100;
        cyc(1);
        for (int i = 1; i <= 32; i++) begin
            frame_tick();
            if (i % 4 == 0)
                probe(100, 100, $sformatf("auto_tick%0d", i), fr_rgb[(i / 8) % 4], ((i / 8) % 4) != 3);
        end

        for (int i = 0; i < 6; i++) frame_tick();
        x = 0; y = 0;
        cyc(5);
        x = 100; y = 100;
        cyc(1);
        probe(100, 100, "hold_one_tick", 12'hFFF, 1'b1);
        frame_tick();
        probe(100, 100, "hold_then_step", 12'hF00, 1'b1);

        ctrl = 6'b000010;
        cyc(1);
        probe(100, 100, "manual_id2", 12'h700, 1'b1);
        ctrl = 6'b000110;
        cyc(1);
        probe(100, 100, "resume_auto", 12'h700, 1'b1);
        for (int i = 0; i < 8; i++) frame_tick();
        probe(100, 100, "resume_step", 12'h000, 1'b0);

        ctrl = 6'b000010;
        cyc(1);
        probe(100, 100, "pre_reset", 12'h700, 1'b1);
        reset = 1'b1;
        cyc(1);
        chk("mid_reset", 12'h000, 1'b0);
        reset = 1'b0;
        chk("release_c0", 12'h000, 1'b0);
        cyc(1);
        chk("release_c1", 12'h000, 1'b0);
        cyc(1);
        chk("release_c2", 12'h700, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
